// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
//   XLEN           operand/result width (64 only)
//   muldiv_op_e    funct3 encodings of the M-extension operations
//   muldiv_state_e sequencer states
//   neg128         two's-complement negate of a double-width value
package muldiv_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN
  } muldiv_state_e;

  function automatic logic [2*XLEN-1:0] neg128(input logic [2*XLEN-1:0] x);
    return ~x + (2*XLEN)'(1);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit, one shift-add / shift-subtract step
// per clock, one operation in flight, result returned through the register
// file write port.
//   clk, nrst            clock, asynchronous active-low reset
//   start, op, rd_addr   issue request, funct3, destination register
//   rs1_data, rs2_data   source operands
//   flush                synchronous abort of the operation in flight
//   busy                 operation accepted and not yet written back
//   wr_en, wr_addr, wrdata  one-cycle writeback strobe, address, data
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wrdata,
  output logic            wr_en
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  opnd_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]  res_q;
  logic [2*XLEN-1:0] acc_q;   // product, or {remainder, quotient}
  logic             neg1_q, neg2_q;
  logic [5:0]       cnt_q;
  logic             fin_done_q;

  // Accept-time operand decode
  logic            sgn1, sgn2, neg1, neg2, div_zero;
  logic [XLEN-1:0] mag1, mag2;

  always_comb begin
    sgn1     = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    sgn2     = op inside {OP_MULH, OP_DIV, OP_REM};
    neg1     = sgn1 & rs1_data[XLEN-1];
    neg2     = sgn2 & rs2_data[XLEN-1];
    mag1     = neg1 ? -rs1_data : rs1_data;
    mag2     = neg2 ? -rs2_data : rs2_data;
    div_zero = op[2] && (rs2_data == '0);
  end

  // Shared adder: multiply adds the multiplicand to the upper half; divide
  // computes (shifted partial remainder - divisor) as a + ~b + 1, where the
  // carry out means "no borrow".
  logic [XLEN-1:0]   add_a, add_b;
  logic              add_cin, ge;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    add_a   = op_q[2] ? acc_q[2*XLEN-2:XLEN-1] : acc_q[2*XLEN-1:XLEN];
    add_b   = op_q[2] ? ~opnd_q : opnd_q;
    add_cin = op_q[2];
    sum     = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_cin};
    // The bit shifted out of the remainder makes it exceed any 64-bit divisor.
    ge      = acc_q[2*XLEN-1] | sum[XLEN];
    if (op_q[2])
      acc_step = {(ge ? sum[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1]), acc_q[XLEN-2:0], ge};
    else if (acc_q[0])
      acc_step = {sum, acc_q[XLEN-1:1]};
    else
      acc_step = {1'b0, acc_q[2*XLEN-1:1]};
  end

  // Sign fix-up and result select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    prod = (neg1_q ^ neg2_q) ? neg128(acc_q) : acc_q;
    case (op_q)
      OP_MUL:                       fin_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:                      fin_res = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  // Sequencer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = div_zero ? ST_FIN : ST_CALC;
      ST_CALC: if (cnt_q == 6'd63) state_d = ST_FIN;
      ST_FIN:  if (fin_done_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  assign busy = (state_q != ST_IDLE);

  // Datapath and writeback registers. FIN takes two cycles: the first
  // registers the corrected result, the second drives the write port.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q       <= OP_MUL;
      rd_q       <= '0;
      opnd_q     <= '0;
      res_q      <= '0;
      acc_q      <= '0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      cnt_q      <= '0;
      fin_done_q <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wrdata     <= '0;
    end else begin
      wr_en <= 1'b0;
      if (flush) begin
        cnt_q      <= '0;
        fin_done_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              op_q       <= muldiv_op_e'(op);
              rd_q       <= rd_addr;
              cnt_q      <= '0;
              fin_done_q <= 1'b0;
              if (div_zero) begin
                // Result is known at accept: quotient all ones, remainder rs1.
                acc_q  <= {rs1_data, {XLEN{1'b1}}};
                opnd_q <= rs2_data;
                neg1_q <= 1'b0;
                neg2_q <= 1'b0;
              end else if (op[2]) begin
                acc_q  <= {{XLEN{1'b0}}, mag1};
                opnd_q <= mag2;
                neg1_q <= neg1;
                neg2_q <= neg2;
              end else begin
                acc_q  <= {{XLEN{1'b0}}, mag2};
                opnd_q <= mag1;
                neg1_q <= neg1;
                neg2_q <= neg2;
              end
            end
          end
          ST_CALC: begin
            acc_q <= acc_step;
            cnt_q <= (cnt_q == 6'd63) ? '0 : cnt_q + 6'd1;
          end
          ST_FIN: begin
            if (!fin_done_q) begin
              res_q      <= fin_res;
              fin_done_q <= 1'b1;
            end else begin
              wr_en      <= (rd_q != '0);
              wrdata     <= res_q;
              wr_addr    <= rd_q;
              fin_done_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// handshake/abort/reset sequences, and random operations compared against
// a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk, nrst, start, flush;
  logic [2:0]  op;
  logic [63:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wrdata;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clk(clk), .nrst(nrst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .flush(flush), .busy(busy), .wr_addr(wr_addr), .wrdata(wrdata),
    .wr_en(wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: RV64M semantics straight from full-width arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic [63:0]        r, minv, ones;
    sa = a; sb = b;
    minv = 64'h8000_0000_0000_0000;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    r = '0;
    case (f)
      3'd0: r = a * b;
      3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[127:64]; end
      3'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      3'd4: r = (b == 0) ? ones : ((a == minv && b == ones) ? minv : 64'(sa / sb));
      3'd5: r = (b == 0) ? ones : a / b;
      3'd6: r = (b == 0) ? a : ((a == minv && b == ones) ? 64'd0 : 64'(sa % sb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic add(input string nm, input logic [2:0] f, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
    vec_t v;
    v.nm = nm; v.f = f; v.a = a; v.b = b; v.rd = rd; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Issue one operation from idle (called at posedge+1) and observe 72 cycles.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp);
    int exp_lat, lat, fall, pulses;
    logic [63:0] got_d;
    logic [4:0]  got_a;
    exp_lat = (f[2] && b == 64'd0) ? 2 : 66;
    op = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, ".busy_rise"}, 64'(busy), 64'd1);
    lat = 0; fall = 0; pulses = 0; got_d = '0; got_a = '0;
    for (int n = 1; n <= 72; n++) begin
      @(posedge clk); #1;
      if (wr_en) begin
        pulses++;
        if (lat == 0) begin lat = n; got_d = wrdata; got_a = wr_addr; end
      end
      if (!busy && fall == 0) fall = n;
    end
    check({nm, ".busy_fall"}, 64'(fall), 64'(exp_lat));
    if (rd != 5'd0) begin
      check({nm, ".lat"},    64'(lat),    64'(exp_lat));
      check({nm, ".pulses"}, 64'(pulses), 64'd1);
      check({nm, ".data"},   got_d,       exp);
      check({nm, ".addr"},   64'(got_a),  64'(rd));
    end else begin
      check({nm, ".x0_pulses"}, 64'(pulses), 64'd0);
    end
  endtask

  task automatic flush_at(input int e);
    int pulses;
    op = 3'd0; rs1_data = 64'd9; rs2_data = 64'd9; rd_addr = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < e; n++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check($sformatf("flush%0d.busy", e), 64'(busy), 64'd0);
    check($sformatf("flush%0d.wr_en", e), 64'(wr_en), 64'd0);
    pulses = 0;
    for (int n = 0; n < 80; n++) begin @(posedge clk); #1; if (wr_en) pulses++; end
    check($sformatf("flush%0d.pulses", e), 64'(pulses), 64'd0);
  endtask

  initial begin
    int lat, pulses;
    logic [63:0] got_d;
    logic [4:0]  got_a;
    logic [2:0]  rf;
    logic [63:0] ra, rb;
    logic [4:0]  rrd;

    nrst = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    @(posedge clk); #1;
    check("rst.busy",    64'(busy),    64'd0);
    check("rst.wr_en",   64'(wr_en),   64'd0);
    check("rst.wrdata",  wrdata,       64'd0);
    check("rst.wr_addr", 64'(wr_addr), 64'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    add("mul",      3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,  64'hFFFF_FFFF_FFFF_FFEB);
    add("mulh",     3'd1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF);
    add("mulhu",    3'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd6,  64'd6);
    add("mulhsu",   3'd2, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd7,  64'd6);
    add("mulhsu_n", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    add("mulhu_max",3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE);
    add("mulh_min", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd31, 64'h4000_0000_0000_0000);
    add("div",      3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD);
    add("rem",      3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF);
    add("div_pn",   3'd4, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd12, 64'hFFFF_FFFF_FFFF_FFF2);
    add("rem_pn",   3'd6, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd13, 64'd2);
    add("divu",     3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd14, 64'h7FFF_FFFF_FFFF_FFFF);
    add("remu",     3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd15, 64'd1);
    add("div0",     3'd4, 64'd42, 64'd0, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF);
    add("divu0",    3'd5, 64'd42, 64'd0, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
    add("remu0",    3'd7, 64'd42, 64'd0, 5'd18, 64'd42);
    add("rem0_neg", 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd19, 64'hFFFF_FFFF_FFFF_FFF9);
    add("div_ovf",  3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd20, 64'h8000_0000_0000_0000);
    add("rem_ovf",  3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd21, 64'd0);
    add("x0",       3'd0, 64'd3, 64'd4, 5'd0, 64'd12);

    foreach (tbl[i]) run_op(tbl[i].nm, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);

    // start held high through a whole operation, inputs changing while busy
    op = 3'd0; rs1_data = 64'd7; rs2_data = 64'hFFFF_FFFF_FFFF_FFFD; rd_addr = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    rs1_data = 64'd100; rd_addr = 5'd9; op = 3'd3;
    lat = 0; pulses = 0; got_d = '0; got_a = '0;
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk); #1;
      if (wr_en) begin
        pulses++;
        if (lat == 0) begin lat = n; got_d = wrdata; got_a = wr_addr; end
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("hold.pulses", 64'(pulses), 64'd1);
    check("hold.lat",    64'(lat),    64'd66);
    check("hold.data",   got_d,       64'hFFFF_FFFF_FFFF_FFEB);
    check("hold.addr",   64'(got_a),  64'd5);

    // back-to-back issue in the writeback cycle
    op = 3'd4; rs1_data = 64'hFFFF_FFFF_FFFF_FFF9; rs2_data = 64'd2; rd_addr = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; got_d = '0;
    for (int n = 1; n <= 80 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (wr_en) begin lat = n; got_d = wrdata; end
    end
    check("b2b.first_lat",  64'(lat), 64'd66);
    check("b2b.first_data", got_d,    64'hFFFF_FFFF_FFFF_FFFD);
    op = 3'd6; rd_addr = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.accept_busy", 64'(busy), 64'd1);
    lat = 0; got_d = '0; got_a = '0;
    for (int n = 1; n <= 80 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (wr_en) begin lat = n; got_d = wrdata; got_a = wr_addr; end
    end
    check("b2b.second_lat",  64'(lat),   64'd66);
    check("b2b.second_data", got_d,      64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b.second_addr", 64'(got_a), 64'd8);
    @(posedge clk); #1;

    flush_at(30);
    flush_at(66);

    // asynchronous reset mid-CALC
    op = 3'd0; rs1_data = 64'd5; rs2_data = 64'd6; rd_addr = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin @(posedge clk); #1; end
    #2;
    nrst = 1'b0;
    #1;
    check("arst.busy",    64'(busy),    64'd0);
    check("arst.wr_en",   64'(wr_en),   64'd0);
    check("arst.wrdata",  wrdata,       64'd0);
    check("arst.wr_addr", 64'(wr_addr), 64'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    pulses = 0;
    for (int n = 0; n < 80; n++) begin @(posedge clk); #1; if (wr_en) pulses++; end
    check("arst.pulses", 64'(pulses), 64'd0);
    run_op("post_rst_mulhu", 3'd3, 64'd3, 64'd5, 5'd4, 64'd0);

    for (int i = 0; i < 40; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      rrd = 5'($urandom_range(1, 31));
      run_op($sformatf("rnd%0d_op%0d", i, rf), rf, ra, rb, rrd, ref_model(rf, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
